// File: rtl/display_mode_sequencer.sv
// rtl/display_mode_sequencer.sv - display path mode sequencer with frame-aligned switching and flush blanking
module display_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FLUSH_FRAMES    = 2,
    parameter int TIMEOUT_FRAMES  = 8
) (
    input  logic       clk_25_vga,
    input  logic       rst,
    input  logic       sw_grayscale,
    input  logic       sw_sobel,
    input  logic       sw_filter,
    input  logic       vsync,
    input  logic       active_area,
    input  logic       filter_ready,
    input  logic       sobel_ready,
    output logic [1:0] mode_sel,
    output logic       out_enable,
    output logic       mode_changed,
    output logic       flush_active,
    output logic       fault,
    output logic [7:0] frame_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FC_W = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0] FLUSH_MIN   = FC_W'(FLUSH_FRAMES);
    localparam logic [FC_W-1:0] TIMEOUT_LIM = FC_W'(TIMEOUT_FRAMES);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // switch bit order: {sobel, grayscale, filter}
    logic [2:0]      sw_meta;
    logic [2:0]      sw_sync;
    logic [1:0]      code;
    logic [1:0]      code_prev;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      req_mode;
    logic            vsync_q;
    logic            fs;
    logic            rdy;
    logic            ready_seen;
    state_t          state;
    logic [1:0]      next_mode;
    logic [FC_W-1:0] flush_cnt;
    logic [FC_W-1:0] flush_next;

    // two-flop synchroniser for the raw board switches
    always_ff @(posedge clk_25_vga or posedge rst) begin
        if (rst) begin
            sw_meta <= 3'b000;
            sw_sync <= 3'b000;
        end else begin
            sw_meta <= {sw_sobel, sw_grayscale, sw_filter};
            sw_sync <= sw_meta;
        end
    end

    // priority encode the synchronised switches into a requested mode code
    always_comb begin
        code = 2'd0;
        if (sw_sync[2])      code = 2'd3;
        else if (sw_sync[1]) code = 2'd1;
        else if (sw_sync[0]) code = 2'd2;
    end

    // debounce: restart the count on any code change, accept after a full stable window
    always_ff @(posedge clk_25_vga or posedge rst) begin
        if (rst) begin
            code_prev <= 2'd0;
            db_cnt    <= '0;
            req_mode  <= 2'd0;
        end else if (code != code_prev) begin
            code_prev <= code;
            db_cnt    <= '0;
        end else if (db_cnt == DB_LAST) begin
            req_mode <= code_prev;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign fs = vsync_q & ~vsync;

    // frame start edge detector and free-running frame counter
    always_ff @(posedge clk_25_vga or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            frame_count <= 8'd0;
        end else begin
            vsync_q <= vsync;
            if (fs) frame_count <= frame_count + 8'd1;
        end
    end

    // readiness of the currently selected path; orig and gray need no line buffers
    always_comb begin
        rdy = 1'b1;
        case (mode_sel)
            2'd2:    rdy = filter_ready;
            2'd3:    rdy = sobel_ready;
            default: rdy = 1'b1;
        endcase
    end

    // remember whether the selected path was ready during active video of this frame
    always_ff @(posedge clk_25_vga or posedge rst) begin
        if (rst) begin
            ready_seen <= 1'b0;
        end else if (fs) begin
            ready_seen <= 1'b0;
        end else if (active_area && rdy) begin
            ready_seen <= 1'b1;
        end
    end

    assign flush_next = flush_cnt + 1'b1;

    // mode sequencing: wait for a frame start to switch, then blank until the new path is ready
    always_ff @(posedge clk_25_vga or posedge rst) begin
        if (rst) begin
            state        <= ST_FLUSH;
            mode_sel     <= 2'd0;
            next_mode    <= 2'd0;
            flush_cnt    <= '0;
            out_enable   <= 1'b0;
            mode_changed <= 1'b0;
            flush_active <= 1'b1;
            fault        <= 1'b0;
        end else begin
            mode_changed <= 1'b0;
            case (state)
                ST_RUN: begin
                    out_enable   <= 1'b1;
                    flush_active <= 1'b0;
                    if (req_mode != mode_sel) begin
                        state     <= ST_PENDING;
                        next_mode <= req_mode;
                    end
                end
                ST_PENDING: begin
                    flush_active <= 1'b0;
                    if (req_mode == mode_sel) begin
                        // cancel takes precedence over a coincident frame start
                        state      <= ST_RUN;
                        out_enable <= 1'b1;
                    end else begin
                        if (req_mode != next_mode) next_mode <= req_mode;
                        if (fs) begin
                            state        <= ST_FLUSH;
                            mode_sel     <= next_mode;
                            mode_changed <= 1'b1;
                            flush_cnt    <= '0;
                            out_enable   <= 1'b0;
                            flush_active <= 1'b1;
                        end
                    end
                end
                default: begin
                    out_enable <= 1'b0;
                    if (req_mode != mode_sel) begin
                        // output stays blanked while pending out of a flush
                        state        <= ST_PENDING;
                        next_mode    <= req_mode;
                        flush_active <= 1'b0;
                    end else if (fs) begin
                        if ((flush_next >= FLUSH_MIN) && ready_seen) begin
                            state        <= ST_RUN;
                            out_enable   <= 1'b1;
                            flush_active <= 1'b0;
                        end else if (flush_next >= TIMEOUT_LIM) begin
                            state        <= ST_RUN;
                            out_enable   <= 1'b1;
                            flush_active <= 1'b0;
                            fault        <= 1'b1;
                        end else if (flush_cnt != TIMEOUT_LIM) begin
                            flush_cnt <= flush_next;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_mode_sequencer.sv
// tb/tb_display_mode_sequencer.sv - directed self-checking bench for display_mode_sequencer
module tb_display_mode_sequencer;

    logic       clk_25_vga = 1'b0;
    logic       rst;
    logic       sw_grayscale, sw_sobel, sw_filter;
    logic       vsync, active_area, filter_ready, sobel_ready;
    logic [1:0] mode_sel;
    logic       out_enable, mode_changed, flush_active, fault;
    logic [7:0] frame_count;

    int n_assert = 0;
    int n_fail   = 0;

    int         mc_count;
    logic       oe_low_seen;
    logic       oe_before, oe_after, fault_after, fa_after;
    logic [1:0] mode_after;
    logic [7:0] fc_after;

    display_mode_sequencer #(
        .DEBOUNCE_CYCLES(16),
        .FLUSH_FRAMES(2),
        .TIMEOUT_FRAMES(4)
    ) dut (
        .clk_25_vga(clk_25_vga),
        .rst(rst),
        .sw_grayscale(sw_grayscale),
        .sw_sobel(sw_sobel),
        .sw_filter(sw_filter),
        .vsync(vsync),
        .active_area(active_area),
        .filter_ready(filter_ready),
        .sobel_ready(sobel_ready),
        .mode_sel(mode_sel),
        .out_enable(out_enable),
        .mode_changed(mode_changed),
        .flush_active(flush_active),
        .fault(fault),
        .frame_count(frame_count)
    );

    always #5 clk_25_vga = ~clk_25_vga;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic account();
        if (mode_changed) mc_count++;
        if (!out_enable) oe_low_seen = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_25_vga);
            account();
            vsync       = 1'b1;
            active_area = 1'b0;
        end
    endtask

    // 40-cycle frame: vsync low for cycles 0-1, active video on cycles 10-29
    task automatic run_frame();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_25_vga);
            account();
            if (k == 0) oe_before = out_enable;
            if (k == 1) begin
                oe_after    = out_enable;
                mode_after  = mode_sel;
                fc_after    = frame_count;
                fault_after = fault;
                fa_after    = flush_active;
            end
            vsync       = (k < 2) ? 1'b0 : 1'b1;
            active_area = (k >= 10 && k < 30) ? 1'b1 : 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        sw_grayscale = 1'b0; sw_sobel = 1'b0; sw_filter = 1'b0;
        vsync = 1'b1; active_area = 1'b0;
        filter_ready = 1'b0; sobel_ready = 1'b0;
        mc_count = 0; oe_low_seen = 1'b0;

        repeat (3) @(negedge clk_25_vga);
        check("reset_mode_sel", 32'(mode_sel), 32'd0);
        check("reset_out_enable", 32'(out_enable), 32'd0);
        check("reset_mode_changed", 32'(mode_changed), 32'd0);
        check("reset_flush_active", 32'(flush_active), 32'd1);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_frame_count", 32'(frame_count), 32'd0);
        rst = 1'b0;

        // start-up flush in mode 0
        idle(5);
        run_frame();
        check("t1_fs1_oe", 32'(oe_after), 32'd0);
        check("t1_fs1_fc", 32'(fc_after), 32'd1);
        run_frame();
        check("t1_fs2_oe_before", 32'(oe_before), 32'd0);
        check("t1_fs2_oe_after", 32'(oe_after), 32'd1);
        check("t1_fs2_fc", 32'(fc_after), 32'd2);
        check("t1_fs2_mode", 32'(mode_after), 32'd0);

        // short switch glitch must not be accepted
        mc_count = 0; oe_low_seen = 1'b0;
        sw_filter = 1'b1;
        idle(10);
        sw_filter = 1'b0;
        idle(30);
        run_frame();
        check("t3_mode", 32'(mode_after), 32'd0);
        check("t3_no_pulse", 32'(mc_count), 32'd0);
        check("t3_oe_never_low", 32'(oe_low_seen), 32'd0);
        check("t3_flush_active", 32'(fa_after), 32'd0);

        // gray requested then withdrawn before the frame start
        mc_count = 0; oe_low_seen = 1'b0;
        sw_grayscale = 1'b1;
        idle(30);
        sw_grayscale = 1'b0;
        idle(30);
        run_frame();
        check("t5_mode", 32'(mode_after), 32'd0);
        check("t5_no_pulse", 32'(mc_count), 32'd0);
        check("t5_oe_never_low", 32'(oe_low_seen), 32'd0);

        // switch to sobel with the sobel path ready
        mc_count = 0;
        sobel_ready = 1'b1;
        sw_sobel = 1'b1;
        idle(30);
        check("t2_pending_mode", 32'(mode_sel), 32'd0);
        run_frame();
        check("t2_oe_before", 32'(oe_before), 32'd1);
        check("t2_mode_after", 32'(mode_after), 32'd3);
        check("t2_oe_after", 32'(oe_after), 32'd0);
        check("t2_flush_active", 32'(fa_after), 32'd1);
        check("t2_one_pulse", 32'(mc_count), 32'd1);
        run_frame();
        check("t2_fs2_oe", 32'(oe_after), 32'd0);
        run_frame();
        check("t2_fs3_oe", 32'(oe_after), 32'd1);
        check("t2_fs3_mode", 32'(mode_after), 32'd3);

        // switch to gauss with its path never ready: timeout forces run and flags fault
        sw_sobel = 1'b0;
        sw_filter = 1'b1;
        idle(30);
        run_frame();
        check("t4_mode_after", 32'(mode_after), 32'd2);
        check("t4_oe_after", 32'(oe_after), 32'd0);
        run_frame();
        check("t4_fs1_oe", 32'(oe_after), 32'd0);
        run_frame();
        check("t4_fs2_oe", 32'(oe_after), 32'd0);
        run_frame();
        check("t4_fs3_oe", 32'(oe_after), 32'd0);
        check("t4_fs3_fault", 32'(fault_after), 32'd0);
        run_frame();
        check("t4_fs4_oe", 32'(oe_after), 32'd1);
        check("t4_fs4_fault", 32'(fault_after), 32'd1);
        check("t4_fs4_mode", 32'(mode_after), 32'd2);
        idle(5);
        check("t4_fault_sticky", 32'(fault), 32'd1);

        // reset in the middle of a sobel flush
        sw_filter = 1'b0;
        sw_sobel = 1'b1;
        idle(30);
        run_frame();
        check("t6_pre_mode", 32'(mode_after), 32'd3);
        check("t6_pre_flush", 32'(fa_after), 32'd1);
        idle(5);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_mode", 32'(mode_sel), 32'd0);
        check("t6_rst_oe", 32'(out_enable), 32'd0);
        check("t6_rst_fault", 32'(fault), 32'd0);
        check("t6_rst_fc", 32'(frame_count), 32'd0);
        check("t6_rst_flush", 32'(flush_active), 32'd1);
        @(negedge clk_25_vga);
        rst = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
